// File: rtl/wb_regfile.sv
// wb_regfile
//   Write-back stage and 32 x 32-bit architectural register file.
//   Selects the write-back value from the MEM/WB outputs and commits it on the
//   rising edge. MEM/WB itself updates on the falling edge, so a commit lands
//   half a cycle after the value is presented. Two combinational decode read
//   ports forward the value being committed this cycle, so WB-to-ID needs no
//   stall. Also keeps a retired-instruction counter and a last-commit trace.
//
// Ports
//   clk           clock, all state updates on posedge
//   reset         synchronous, active-high reset
//   haveInstrIn   MEM/WB slot holds a real instruction (0 = bubble)
//   readDataIn    load value from MEM/WB
//   ALUOutIn      ALU result from MEM/WB
//   regDstIn      destination register
//   regWrite      write-back enable
//   memToReg      1 = write readDataIn, 0 = write ALUOutIn
//   readReg1/2    decode read addresses
//   readData1/2   decode read data (combinational, with bypass)
//   wbData        selected write-back value (combinational)
//   retiredCount  count of retired real instructions (wraps)
//   lastWbValid   at least one commit since reset
//   lastWbReg     destination of the most recent commit
//   lastWbData    value of the most recent commit
module wb_regfile #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             haveInstrIn,
   input  logic [31:0]      readDataIn,
   input  logic [31:0]      ALUOutIn,
   input  logic [4:0]       regDstIn,
   input  logic             regWrite,
   input  logic             memToReg,
   input  logic [4:0]       readReg1,
   input  logic [4:0]       readReg2,
   output logic [31:0]      readData1,
   output logic [31:0]      readData2,
   output logic [31:0]      wbData,
   output logic [CNT_W-1:0] retiredCount,
   output logic             lastWbValid,
   output logic [4:0]       lastWbReg,
   output logic [31:0]      lastWbData
);

   logic [31:0] regs_r [0:31];
   logic        we_s;

   // Write-back mux; purely combinational, not gated by reset or bubbles.
   assign wbData = memToReg ? readDataIn : ALUOutIn;

   // Commit enable; writes to $zero are dropped here so r0 is never written.
   assign we_s = !reset && regWrite && haveInstrIn && (regDstIn != 5'd0);

   // Register array: cleared on reset, one commit per cycle otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            regs_r[i] <= 32'h0000_0000;
         end
      end else if (we_s) begin
         regs_r[regDstIn] <= wbData;
      end
   end

   // Last-commit trace for the bench; only real register commits update it.
   always_ff @(posedge clk) begin
      if (reset) begin
         lastWbValid <= 1'b0;
         lastWbReg   <= 5'd0;
         lastWbData  <= 32'h0000_0000;
      end else if (we_s) begin
         lastWbValid <= 1'b1;
         lastWbReg   <= regDstIn;
         lastWbData  <= wbData;
      end
   end

   // Retired counter: every real instruction counts, including stores,
   // branches and writes to $zero; bubbles never count. Wraps silently.
   always_ff @(posedge clk) begin
      if (reset) begin
         retiredCount <= '0;
      end else if (haveInstrIn) begin
         retiredCount <= retiredCount + CNT_W'(1);
      end
   end

   // Read port 1: forced to 0 in reset, r0 reads 0, else bypass or array.
   always_comb begin
      readData1 = 32'h0000_0000;
      if (reset || (readReg1 == 5'd0)) begin
         readData1 = 32'h0000_0000;
      end else if (we_s && (readReg1 == regDstIn)) begin
         readData1 = wbData;
      end else begin
         readData1 = regs_r[readReg1];
      end
   end

   // Read port 2: same rules as port 1; both may bypass at once.
   always_comb begin
      readData2 = 32'h0000_0000;
      if (reset || (readReg2 == 5'd0)) begin
         readData2 = 32'h0000_0000;
      end else if (we_s && (readReg2 == regDstIn)) begin
         readData2 = wbData;
      end else begin
         readData2 = regs_r[readReg2];
      end
   end

endmodule
